// File: rtl/opamp_stim_pkg.sv
// Shared types and constants for the opamp sigma-delta stimulus block.
// Holds the FSM state encoding, the code width and the default window/sync sizes.
package opamp_stim_pkg;

   localparam int CODE_W          = 8;
   localparam int WIN_LOG2_DEF    = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RAMP = 2'd2
   } state_e;

endpackage

// File: rtl/opamp_sync.sv
// Multi-flop synchronizer for the asynchronous opamp feedback sense.
// Depth is clamped to at least two flops; every stage clears on reset.
module opamp_sync
   import opamp_stim_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [N-1:0] sh_q;
   logic [N-1:0] sh_d;

   always_comb begin
      sh_d = {sh_q[N-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign q = sh_q[N-1];

endmodule

// File: rtl/opamp_sd_stim.sv
// First-order sigma-delta opamp stimulus with windowed feedback duty measurement.
// Optional ramp mode is built only when OPAMP_SD_STIM_RAMP_EN is defined.
module opamp_sd_stim
   import opamp_stim_pkg::*;
#(
   parameter int WIN_LOG2    = WIN_LOG2_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [CODE_W-1:0]   code_in,
   input  logic                code_valid,
   output logic                code_ready,
   input  logic                mode,
   output logic                pdm_out,
   input  logic                fb_in,
   output logic [WIN_LOG2-1:0] meas_out,
   output logic                meas_valid
);

   localparam int OW = WIN_LOG2 + 1;
   localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;

   logic fb_s;

   opamp_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (fb_in),
      .q  (fb_s)
   );

   state_e              state_q, state_d;
   state_e              run_st;
   logic [CODE_W-1:0]   acc_q, acc_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CODE_W-1:0]   pend_code_q, pend_code_d;
   logic                pend_q, pend_d;
   logic                pdm_q, pdm_d;
   logic                mv_q, mv_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [WIN_LOG2-1:0] meas_q, meas_d;
   logic [OW-1:0]       ones_q, ones_d;
   logic [CODE_W:0]     sum;
   logic                xfer;
   logic                bnd;

`ifdef OPAMP_SD_STIM_RAMP_EN
   assign run_st = mode ? ST_RAMP : ST_RUN;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign run_st      = ST_RUN;
`endif

   assign sum  = {1'b0, acc_q} + {1'b0, code_q};
   assign xfer = code_valid & ~pend_q;
   assign bnd  = (win_q == WIN_MAX);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      pdm_d       = pdm_q;
      win_d       = win_q;
      ones_d      = ones_q;
      meas_d      = meas_q;
      mv_d        = 1'b0;
      code_d      = code_q;
      pend_d      = pend_q;
      pend_code_d = pend_code_q;

      if (xfer) begin
         pend_d      = 1'b1;
         pend_code_d = code_in;
      end

      if (!ena) begin
         // a dropped enable throws away the partial window
         state_d = ST_IDLE;
         acc_d   = '0;
         pdm_d   = 1'b0;
         win_d   = '0;
         ones_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = run_st;
               acc_d   = '0;
               pdm_d   = 1'b0;
               win_d   = '0;
               ones_d  = OW'(fb_s);
            end
            default: begin
               {pdm_d, acc_d} = sum;
               win_d  = win_q + 1'b1;
               ones_d = ones_q + OW'(fb_s);
               if (bnd) begin
                  meas_d  = ones_q[WIN_LOG2] ? '1 : ones_q[WIN_LOG2-1:0];
                  mv_d    = 1'b1;
                  ones_d  = OW'(fb_s);
                  state_d = run_st;
                  if (pend_q) begin
                     code_d = pend_code_q;
                     pend_d = 1'b0;
                  end
`ifdef OPAMP_SD_STIM_RAMP_EN
                  else if (state_q == ST_RAMP) begin
                     code_d = code_q + 1'b1;
                  end
`endif
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         pdm_q       <= 1'b0;
         win_q       <= '0;
         ones_q      <= '0;
         meas_q      <= '0;
         mv_q        <= 1'b0;
         code_q      <= '0;
         pend_q      <= 1'b0;
         pend_code_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         pdm_q       <= pdm_d;
         win_q       <= win_d;
         ones_q      <= ones_d;
         meas_q      <= meas_d;
         mv_q        <= mv_d;
         code_q      <= code_d;
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
      end
   end

   assign code_ready = ~pend_q;
   assign pdm_out    = pdm_q;
   assign meas_out   = meas_q;
   assign meas_valid = mv_q;

endmodule

// File: tb/tb_opamp_sd_stim.sv
// Self-checking bench for opamp_sd_stim: duty per window, measurement, code handoff,
// ramp, enable drop and asynchronous reset against a window-level reference model.
module tb_opamp_sd_stim;

   localparam int WL = 8;
   localparam int SS = 2;
   localparam int WN = 256;
`ifdef OPAMP_SD_STIM_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [7:0]    code_in;
   logic          code_valid;
   logic          code_ready;
   logic          mode;
   logic          pdm_out;
   logic          fb_in;
   logic [WL-1:0] meas_out;
   logic          meas_valid;

   int checks = 0;
   int errors = 0;

   // fb value seen by the DUT at each rising edge; index = edge number
   bit hist[$];
   int edge_n;
   int fb_mode;
   int pdm_acc;
   int duty_last;
   int mv_edge;
   int meas_s;
   bit mv;

   always #5 clk = ~clk;

   opamp_sd_stim #(
      .WIN_LOG2   (WL),
      .SYNC_STAGES(SS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .code_in   (code_in),
      .code_valid(code_valid),
      .code_ready(code_ready),
      .mode      (mode),
      .pdm_out   (pdm_out),
      .fb_in     (fb_in),
      .meas_out  (meas_out),
      .meas_valid(meas_valid)
   );

   task automatic tick();
      @(posedge clk);
      hist.push_back(fb_in);
      edge_n++;
      #1;
      pdm_acc += int'(pdm_out);
      mv = meas_valid;
      if (meas_valid) begin
         duty_last = pdm_acc;
         pdm_acc   = 0;
         mv_edge   = edge_n;
         meas_s    = int'(meas_out);
      end
      if (fb_mode == 2) fb_in = 1'($urandom_range(0, 1));
      else              fb_in = (fb_mode == 1);
   endtask

   // high count of the synchronized feedback over the WN edges before edge v
   function automatic int exp_meas(input int v);
      int s = 0;
      for (int k = v - WN; k < v; k++)
         if (k >= SS) s += int'(hist[k - SS]);
      return (s > WN - 1) ? WN - 1 : s;
   endfunction

   task automatic wait_mv(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick();
         if (mv) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; mode = 1'b0;
      code_valid = 1'b0; code_in = 8'h00;
      fb_mode = 0; fb_in = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      hist.delete();
      hist.push_back(1'b0);
      edge_n = 0; pdm_acc = 0; mv = 1'b0;
   endtask

   task automatic offer(input logic [7:0] c);
      code_in = c;
      code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (pdm_out !== 1'b0) begin
         errors++; $display("FAIL reset_pdm got %b want 0", pdm_out);
      end
      checks++;
      if (meas_out !== '0) begin
         errors++; $display("FAIL reset_meas got %0d want 0", meas_out);
      end
      checks++;
      if (meas_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mv got %b want 0", meas_valid);
      end
      checks++;
      if (code_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", code_ready);
      end
   endtask

   task automatic test_static();
      bit ok;
      int prev;
      logic [7:0] c;
      do_reset();
      fb_mode = 2;
      offer(8'h40);
      ena = 1'b1; mode = 1'b0; pdm_acc = 0;
      repeat (100) tick();
      checks++;
      if (code_ready !== 1'b0) begin
         errors++; $display("FAIL static_ready_hold got %b want 0", code_ready);
      end
      wait_mv(300, ok);
      checks++;
      if (!ok || duty_last != 0) begin
         errors++; $display("FAIL static_win0 ok %0d duty %0d want 0", ok, duty_last);
      end
      checks++;
      if (code_ready !== 1'b1) begin
         errors++; $display("FAIL static_ready_free got %b want 1", code_ready);
      end
      for (int w = 0; w < 2; w++) begin
         wait_mv(300, ok);
         checks++;
         if (!ok || duty_last != 64) begin
            errors++; $display("FAIL static_duty40 ok %0d duty %0d want 64", ok, duty_last);
         end
         checks++;
         if (meas_s != exp_meas(mv_edge)) begin
            errors++; $display("FAIL static_meas got %0d want %0d", meas_s, exp_meas(mv_edge));
         end
      end
      prev = 64;
      for (int n = 0; n < 5; n++) begin
         c = 8'($urandom_range(0, 255));
         if (n < 4) offer(c);
         wait_mv(300, ok);
         checks++;
         if (!ok || duty_last != prev) begin
            errors++; $display("FAIL rand_duty ok %0d duty %0d want %0d", ok, duty_last, prev);
         end
         checks++;
         if (meas_s != exp_meas(mv_edge)) begin
            errors++; $display("FAIL rand_meas got %0d want %0d", meas_s, exp_meas(mv_edge));
         end
         if (n < 4) prev = int'(c);
      end
   endtask

   task automatic test_meas_sat();
      bit ok;
      int last;
      for (int lvl = 1; lvl >= 0; lvl--) begin
         fb_mode = lvl;
         last = mv_edge;
         for (int w = 0; w < 3; w++) begin
            wait_mv(300, ok);
            checks++;
            if (!ok || mv_edge - last != WN) begin
               errors++; $display("FAIL sat_period ok %0d gap %0d want %0d", ok, mv_edge - last, WN);
            end
            last = mv_edge;
            checks++;
            if (meas_s != exp_meas(mv_edge) || (w > 0 && meas_s != lvl * 255)) begin
               errors++; $display("FAIL sat_meas lvl %0d got %0d want %0d", lvl, meas_s, exp_meas(mv_edge));
            end
            tick();
            checks++;
            if (mv) begin
               errors++; $display("FAIL sat_pulse got 1 want 0");
            end
         end
      end
   endtask

   task automatic test_boundary_xfer();
      bit ok;
      int v1;
      do_reset();
      fb_mode = 2;
      offer(8'h80);
      ena = 1'b1; pdm_acc = 0;
      wait_mv(300, ok);
      v1 = edge_n;
      repeat (WN - 1) tick();
      checks++;
      if (code_ready !== 1'b1) begin
         errors++; $display("FAIL bx_ready_pre got %b want 1", code_ready);
      end
      code_in = 8'h10; code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
      checks++;
      if (!mv || edge_n != v1 + WN || duty_last != 8'h80) begin
         errors++; $display("FAIL bx_boundary mv %0d edge %0d duty %0d want 1 %0d 128", mv, edge_n, duty_last, v1 + WN);
      end
      checks++;
      if (code_ready !== 1'b0) begin
         errors++; $display("FAIL bx_ready_held got %b want 0", code_ready);
      end
      wait_mv(300, ok);
      checks++;
      if (!ok || duty_last != 8'h80) begin
         errors++; $display("FAIL bx_old_code ok %0d duty %0d want 128", ok, duty_last);
      end
      checks++;
      if (code_ready !== 1'b1) begin
         errors++; $display("FAIL bx_ready_post got %b want 1", code_ready);
      end
      wait_mv(300, ok);
      checks++;
      if (!ok || duty_last != 8'h10) begin
         errors++; $display("FAIL bx_new_code ok %0d duty %0d want 16", ok, duty_last);
      end
   endtask

   task automatic test_ramp();
      bit ok;
      int e;
      do_reset();
      fb_mode = 2;
      offer(8'hFE);
      mode = 1'b1; ena = 1'b1; pdm_acc = 0;
      wait_mv(300, ok);
      checks++;
      if (!ok || duty_last != 0) begin
         errors++; $display("FAIL ramp_win0 ok %0d duty %0d want 0", ok, duty_last);
      end
      for (int n = 0; n < 4; n++) begin
         e = RAMP ? (254 + n) % 256 : 254;
         wait_mv(300, ok);
         checks++;
         if (!ok || duty_last != e) begin
            errors++; $display("FAIL ramp_step%0d ok %0d duty %0d want %0d", n, ok, duty_last, e);
         end
      end
      repeat (50) tick();
      mode = 1'b0;
      for (int n = 0; n < 3; n++) begin
         e = RAMP ? ((n == 0) ? 2 : 3) : 254;
         wait_mv(300, ok);
         checks++;
         if (!ok || duty_last != e) begin
            errors++; $display("FAIL ramp_stop%0d ok %0d duty %0d want %0d", n, ok, duty_last, e);
         end
      end
   endtask

   task automatic test_ena_drop();
      bit ok;
      int nmv;
      int npdm;
      int n;
      do_reset();
      fb_mode = 2;
      offer(8'hFF);
      ena = 1'b1; pdm_acc = 0;
      wait_mv(300, ok);
      repeat (100) tick();
      ena = 1'b0;
      tick();
      checks++;
      if (pdm_out !== 1'b0) begin
         errors++; $display("FAIL drop_pdm got %b want 0", pdm_out);
      end
      nmv = int'(mv); npdm = 0;
      repeat (300) begin
         tick();
         nmv += int'(mv);
         npdm += int'(pdm_out);
      end
      checks++;
      if (nmv != 0 || npdm != 0) begin
         errors++; $display("FAIL drop_idle mv %0d pdm %0d want 0 0", nmv, npdm);
      end
      pdm_acc = 0; ena = 1'b1;
      n = 0; ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         n++;
         if (mv) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || n != WN + 1) begin
         errors++; $display("FAIL reen_latency ok %0d got %0d want %0d", ok, n, WN + 1);
      end
      checks++;
      if (duty_last != 255 || meas_s != exp_meas(mv_edge)) begin
         errors++; $display("FAIL reen_window duty %0d meas %0d want 255 %0d", duty_last, meas_s, exp_meas(mv_edge));
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      fb_mode = 1;
      wait_mv(300, ok);
      wait_mv(300, ok);
      checks++;
      if (!ok || meas_out !== 8'd255) begin
         errors++; $display("FAIL ar_pre ok %0d meas %0d want 255", ok, meas_out);
      end
      offer(8'h33);
      repeat (10) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (pdm_out !== 1'b0 || meas_valid !== 1'b0) begin
         errors++; $display("FAIL ar_pdm_mv got %b %b want 0 0", pdm_out, meas_valid);
      end
      checks++;
      if (meas_out !== '0) begin
         errors++; $display("FAIL ar_meas got %0d want 0", meas_out);
      end
      checks++;
      if (code_ready !== 1'b1) begin
         errors++; $display("FAIL ar_ready got %b want 1", code_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete();
      hist.push_back(1'b0);
      edge_n = 0; pdm_acc = 0; mv = 1'b0;
      for (int w = 0; w < 2; w++) begin
         wait_mv(300, ok);
         checks++;
         if (!ok || duty_last != 0 || meas_s != exp_meas(mv_edge)) begin
            errors++; $display("FAIL ar_post%0d ok %0d duty %0d meas %0d want 0 %0d", w, ok, duty_last, meas_s, exp_meas(mv_edge));
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_meas_sat();
      test_boundary_xfer();
      test_ramp();
      test_ena_drop();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
